// File: rtl/mtsp_lmb_pkg.sv
// mtsp_lmb_pkg -- shared types and index-width helpers for the banked local
// memory block (mtsp_lmb_banked).
//
// Contents:
//   lmb_req_t   request bundle (en, we, addr, wdata, mask). It is sized for the
//               largest supported configuration; each instance uses the
//               low-order bits of addr/wdata/mask that its parameters call for.
//   bank_bits() width of the bank-select field (at least 1 bit).
//   row_bits()  width of the in-bank row field (at least 1 bit).
package mtsp_lmb_pkg;

  localparam int unsigned LMB_AW_MAX = 32;
  localparam int unsigned LMB_DW_MAX = 1024;
  localparam int unsigned LMB_MW_MAX = LMB_DW_MAX / 32;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [LMB_AW_MAX-1:0] addr;
    logic [LMB_DW_MAX-1:0] wdata;
    logic [LMB_MW_MAX-1:0] mask;   // one bit per 32-bit DWORD, 1 = write
  } lmb_req_t;

  // A single bank still needs a 1-bit index signal to keep port widths legal.
  function automatic int unsigned bank_bits(input int unsigned bank_count);
    return (bank_count > 1) ? $clog2(bank_count) : 1;
  endfunction

  function automatic int unsigned row_bits(input int unsigned bank_depth);
    return (bank_depth > 1) ? $clog2(bank_depth) : 1;
  endfunction

endpackage

// File: rtl/mtsp_lmb_bank_arbiter.sv
// mtsp_lmb_bank_arbiter -- per-bank grant between the core port and the
// external port, plus the external starvation counter.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   core_en, core_bank     core request and its target bank
//   ex_en, ex_bank         external request and its target bank
//   core_ready, ex_ready   request accepted this cycle
//   core_grant, ex_grant   one-hot bank grants (never both set for a bank)
//
// The core owns a contested bank until the external port has been turned
// away STARVE_LIMIT cycles in a row; then the external port gets that cycle.
module mtsp_lmb_bank_arbiter #(
  parameter int unsigned BANK_COUNT   = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned BW           = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_en,
  input  logic [BW-1:0]         core_bank,
  input  logic                  ex_en,
  input  logic [BW-1:0]         ex_bank,
  output logic                  core_ready,
  output logic                  ex_ready,
  output logic [BANK_COUNT-1:0] core_grant,
  output logic [BANK_COUNT-1:0] ex_grant
);

  logic [7:0] starve_cnt;
  logic       conflict;
  logic       ex_wins;

  // NOTE: every output of this block gets a default before any condition so
  // no path leaves a value unassigned and infers a latch.
  always_comb begin
    core_grant = '0;
    ex_grant   = '0;
    conflict   = core_en && ex_en && (core_bank == ex_bank);
    ex_wins    = conflict && (starve_cnt == 8'(STARVE_LIMIT));
    // Requests seen during reset are never accepted.
    core_ready = !rst && core_en && !ex_wins;
    ex_ready   = !rst && ex_en && (!conflict || ex_wins);
    for (int b = 0; b < BANK_COUNT; b++) begin
      core_grant[b] = core_ready && (core_bank == BW'(b));
      ex_grant[b]   = ex_ready && (ex_bank == BW'(b));
    end
  end

  // Counts consecutive refused external cycles, saturating at the limit;
  // any accepted or absent external request restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (ex_en && !ex_ready) begin
      if (starve_cnt != 8'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 8'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/sram_single.sv
// sram_single -- single-port synchronous SRAM with per-DWORD write enables.
//
// Ports:
//   clk    clock
//   en     access enable (read or write this cycle)
//   we     1 = write, 0 = read
//   addr   word address
//   wdata  write data
//   wmask  per-32-bit-DWORD write enable, 1 = write that DWORD
//   rdata  read data, valid the cycle after a read; holds otherwise
module sram_single #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 256
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH)-1:0]       addr,
  input  logic [WIDTH-1:0]               wdata,
  input  logic [WIDTH/32-1:0]            wmask,
  output logic [WIDTH-1:0]               rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately left out of any reset so it maps
  // onto a RAM macro; contents survive a block reset.
  // NOTE: clocked state always uses non-blocking assignments so every
  // register samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < WIDTH / 32; i++) begin
          if (wmask[i]) mem[addr][i*32 +: 32] <= wdata[i*32 +: 32];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mtsp_lmb_banked.sv
// mtsp_lmb_banked -- banked local memory block shared by a core port and an
// external port. Words are interleaved across BANK_COUNT single-port SRAMs
// (bank = low address bits, row = upper bits), so requests to different banks
// proceed in parallel. Reads return two cycles after acceptance: external
// reads on EX_RDATA, core reads as a two-register write-back on EW0/EW1.
//
// Optional feature: define MTSP_LMB_WRITE_MASK_EN to add CORE_WMASK/EX_WMASK
// (one bit per 32-bit DWORD, 1 = write). Without it every write is full-word.
//
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   CORE_EN/WRITE/ADDR/WDATA/DST     core request, DST = write-back base GPR
//   CORE_READY                       core request accepted this cycle
//   EX_EN/WE/ADDR/WDATA              external request
//   EX_READY                         external request accepted this cycle
//   EX_RVALID, EX_RDATA              external read return (data holds)
//   EW_EN, EW0/EW1_ADDR, EW0/EW1_DATA  core read write-back (values hold)
module mtsp_lmb_banked
  import mtsp_lmb_pkg::*;
#(
  parameter int unsigned CORE_ID      = 0,
  parameter int unsigned BANK_COUNT   = 4,
  parameter int unsigned BANK_DEPTH   = 256,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned GPR_COUNT    = 64,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      CORE_EN,
  input  logic                                      CORE_WRITE,
  input  logic [$clog2(BANK_COUNT*BANK_DEPTH)-1:0]  CORE_ADDR,
  input  logic [DATA_WIDTH-1:0]                     CORE_WDATA,
`ifdef MTSP_LMB_WRITE_MASK_EN
  input  logic [DATA_WIDTH/32-1:0]                  CORE_WMASK,
`endif
  input  logic [$clog2(GPR_COUNT)-1:0]              CORE_DST,
  output logic                                      CORE_READY,
  input  logic                                      EX_EN,
  input  logic                                      EX_WE,
  input  logic [$clog2(BANK_COUNT*BANK_DEPTH)-1:0]  EX_ADDR,
  input  logic [DATA_WIDTH-1:0]                     EX_WDATA,
`ifdef MTSP_LMB_WRITE_MASK_EN
  input  logic [DATA_WIDTH/32-1:0]                  EX_WMASK,
`endif
  output logic                                      EX_READY,
  output logic                                      EX_RVALID,
  output logic [DATA_WIDTH-1:0]                     EX_RDATA,
  output logic                                      EW_EN,
  output logic [$clog2(GPR_COUNT)-1:0]              EW0_ADDR,
  output logic [$clog2(GPR_COUNT)-1:0]              EW1_ADDR,
  output logic [DATA_WIDTH/2-1:0]                   EW0_DATA,
  output logic [DATA_WIDTH/2-1:0]                   EW1_DATA
);

  localparam int unsigned AW = $clog2(BANK_COUNT * BANK_DEPTH);
  localparam int unsigned BW = bank_bits(BANK_COUNT);
  localparam int unsigned RW = row_bits(BANK_DEPTH);
  localparam int unsigned GW = $clog2(GPR_COUNT);
  localparam int unsigned MW = DATA_WIDTH / 32;
  localparam int unsigned HW = DATA_WIDTH / 2;

  // Bank counts are powers of two, so these reduce to bit slices.
  function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] a);
    return BW'(a % AW'(BANK_COUNT));
  endfunction

  function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
    return RW'(a / AW'(BANK_COUNT));
  endfunction

  lmb_req_t core_req;
  lmb_req_t ex_req;

  always_comb begin
    core_req                   = '0;
    core_req.en                = CORE_EN;
    core_req.we                = CORE_WRITE;
    core_req.addr[AW-1:0]      = CORE_ADDR;
    core_req.wdata[DATA_WIDTH-1:0] = CORE_WDATA;
    ex_req                     = '0;
    ex_req.en                  = EX_EN;
    ex_req.we                  = EX_WE;
    ex_req.addr[AW-1:0]        = EX_ADDR;
    ex_req.wdata[DATA_WIDTH-1:0] = EX_WDATA;
`ifdef MTSP_LMB_WRITE_MASK_EN
    core_req.mask[MW-1:0]      = CORE_WMASK;
    ex_req.mask[MW-1:0]        = EX_WMASK;
`else
    core_req.mask[MW-1:0]      = '1;
    ex_req.mask[MW-1:0]        = '1;
`endif
  end

  // The request struct is sized for the largest configuration; the spare
  // high bits and CORE_ID (only meaningful to the simulation-side mirror)
  // are folded here so they are intentionally consumed.
  logic unused_req;
  assign unused_req = ^{core_req, ex_req, 32'(CORE_ID)};

  logic [BW-1:0]         core_bank;
  logic [BW-1:0]         ex_bank;
  logic [BANK_COUNT-1:0] core_grant;
  logic [BANK_COUNT-1:0] ex_grant;

  assign core_bank = bank_of(core_req.addr[AW-1:0]);
  assign ex_bank   = bank_of(ex_req.addr[AW-1:0]);

  mtsp_lmb_bank_arbiter #(
    .BANK_COUNT  (BANK_COUNT),
    .STARVE_LIMIT(STARVE_LIMIT),
    .BW          (BW)
  ) u_arbiter (
    .clk       (CLK),
    .rst       (RST),
    .core_en   (core_req.en),
    .core_bank (core_bank),
    .ex_en     (ex_req.en),
    .ex_bank   (ex_bank),
    .core_ready(CORE_READY),
    .ex_ready  (EX_READY),
    .core_grant(core_grant),
    .ex_grant  (ex_grant)
  );

  logic [DATA_WIDTH-1:0] bank_rdata [BANK_COUNT];

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    logic                  bank_en;
    logic                  bank_we;
    logic [RW-1:0]         bank_row;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [MW-1:0]         bank_mask;

    // The arbiter never grants one bank to both ports, so the core grant
    // alone picks the source.
    always_comb begin
      bank_en = core_grant[b] || ex_grant[b];
      if (core_grant[b]) begin
        bank_we    = core_req.we;
        bank_row   = row_of(core_req.addr[AW-1:0]);
        bank_wdata = core_req.wdata[DATA_WIDTH-1:0];
        bank_mask  = core_req.mask[MW-1:0];
      end else begin
        bank_we    = ex_req.we;
        bank_row   = row_of(ex_req.addr[AW-1:0]);
        bank_wdata = ex_req.wdata[DATA_WIDTH-1:0];
        bank_mask  = ex_req.mask[MW-1:0];
      end
    end

    sram_single #(
      .DEPTH(BANK_DEPTH),
      .WIDTH(DATA_WIDTH)
    ) u_sram (
      .clk  (CLK),
      .en   (bank_en),
      .we   (bank_we),
      .addr (bank_row),
      .wdata(bank_wdata),
      .wmask(bank_mask),
      .rdata(bank_rdata[b])
    );
  end

  // Stage 1 tracks reads whose SRAM access is under way; stage 2 registers
  // the returned word onto the output ports.
  logic          ex_rd_p1;
  logic          core_rd_p1;
  logic [BW-1:0] ex_bank_p1;
  logic [BW-1:0] core_bank_p1;
  logic [GW-1:0] core_dst_p1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      // Clearing the stage-1 valids drops any read in flight.
      ex_rd_p1     <= 1'b0;
      core_rd_p1   <= 1'b0;
      ex_bank_p1   <= '0;
      core_bank_p1 <= '0;
      core_dst_p1  <= '0;
      EX_RVALID    <= 1'b0;
      EX_RDATA     <= '0;
      EW_EN        <= 1'b0;
      EW0_ADDR     <= '0;
      EW1_ADDR     <= '0;
      EW0_DATA     <= '0;
      EW1_DATA     <= '0;
    end else begin
      ex_rd_p1   <= EX_READY && !ex_req.we;
      core_rd_p1 <= CORE_READY && !core_req.we;
      if (EX_READY) ex_bank_p1 <= ex_bank;
      if (CORE_READY) begin
        core_bank_p1 <= core_bank;
        core_dst_p1  <= CORE_DST;
      end

      EX_RVALID <= ex_rd_p1;
      if (ex_rd_p1) EX_RDATA <= bank_rdata[ex_bank_p1];

      EW_EN <= core_rd_p1;
      if (core_rd_p1) begin
        EW0_ADDR <= core_dst_p1;
        EW1_ADDR <= core_dst_p1 + GW'(1);   // wraps modulo GPR_COUNT
        EW0_DATA <= bank_rdata[core_bank_p1][DATA_WIDTH-1:HW];
        EW1_DATA <= bank_rdata[core_bank_p1][HW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mtsp_lmb_banked.sv
// tb_mtsp_lmb_banked -- self-checking bench for mtsp_lmb_banked (default
// parameters). A cycle-level reference model computes grants, the starvation
// rule, memory contents and the two-cycle read returns from plain arrays.
// Define MTSP_LMB_WRITE_MASK_EN to also exercise the DWORD write mask.
module tb_mtsp_lmb_banked;

  localparam int BC = 4;
  localparam int BD = 256;
  localparam int DW = 256;
  localparam int GC = 64;
  localparam int SL = 8;
  localparam int AW = 10;
  localparam int GW = 6;
  localparam int MW = DW / 32;
  localparam int HW = DW / 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CORE_EN = 1'b0, CORE_WRITE = 1'b0;
  logic [AW-1:0] CORE_ADDR = '0;
  logic [DW-1:0] CORE_WDATA = '0;
  logic [GW-1:0] CORE_DST = '0;
  logic          CORE_READY;
  logic          EX_EN = 1'b0, EX_WE = 1'b0;
  logic [AW-1:0] EX_ADDR = '0;
  logic [DW-1:0] EX_WDATA = '0;
  logic          EX_READY, EX_RVALID;
  logic [DW-1:0] EX_RDATA;
  logic          EW_EN;
  logic [GW-1:0] EW0_ADDR, EW1_ADDR;
  logic [HW-1:0] EW0_DATA, EW1_DATA;
`ifdef MTSP_LMB_WRITE_MASK_EN
  logic [MW-1:0] CORE_WMASK = '1;
  logic [MW-1:0] EX_WMASK = '1;
`endif

  always #5 CLK = ~CLK;

  mtsp_lmb_banked #(
    .CORE_ID(0), .BANK_COUNT(BC), .BANK_DEPTH(BD), .DATA_WIDTH(DW),
    .GPR_COUNT(GC), .STARVE_LIMIT(SL)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CORE_EN(CORE_EN), .CORE_WRITE(CORE_WRITE), .CORE_ADDR(CORE_ADDR),
    .CORE_WDATA(CORE_WDATA),
`ifdef MTSP_LMB_WRITE_MASK_EN
    .CORE_WMASK(CORE_WMASK),
`endif
    .CORE_DST(CORE_DST), .CORE_READY(CORE_READY),
    .EX_EN(EX_EN), .EX_WE(EX_WE), .EX_ADDR(EX_ADDR), .EX_WDATA(EX_WDATA),
`ifdef MTSP_LMB_WRITE_MASK_EN
    .EX_WMASK(EX_WMASK),
`endif
    .EX_READY(EX_READY), .EX_RVALID(EX_RVALID), .EX_RDATA(EX_RDATA),
    .EW_EN(EW_EN), .EW0_ADDR(EW0_ADDR), .EW1_ADDR(EW1_ADDR),
    .EW0_DATA(EW0_DATA), .EW1_DATA(EW1_DATA)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mem [BC*BD];
  int            starve = 0;
  int            cyc = 0;
  bit            exp_rv   [4096];
  logic [DW-1:0] exp_rd   [4096];
  bit            exp_ew   [4096];
  int            exp_dst  [4096];
  logic [DW-1:0] exp_word [4096];
  logic [DW-1:0] last_rd = '0;
  logic [GW-1:0] last_ew0a = '0, last_ew1a = '0;
  logic [HW-1:0] last_ew0d = '0, last_ew1d = '0;
  bit            core_acc = 1'b0, ex_acc = 1'b0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MW; i++) if (m[i]) r[i*32 +: 32] = new_w[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < MW; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // One clock cycle: check the accept decision for the inputs currently
  // driven, advance the model, then check the registered outputs.
  task automatic tick();
    bit            cr, er, conflict, rst_now;
    logic [MW-1:0] cm, em;
`ifdef MTSP_LMB_WRITE_MASK_EN
    cm = CORE_WMASK;
    em = EX_WMASK;
`else
    cm = '1;
    em = '1;
`endif
    #1;
    conflict = CORE_EN && EX_EN && ((CORE_ADDR % BC) == (EX_ADDR % BC));
    if (RST) begin
      cr = 1'b0;
      er = 1'b0;
    end else begin
      er = EX_EN && (!conflict || starve == SL);
      cr = CORE_EN && !(conflict && starve == SL);
    end
    check("core_ready", {255'b0, CORE_READY}, {255'b0, cr});
    check("ex_ready",   {255'b0, EX_READY},   {255'b0, er});
    core_acc = cr;
    ex_acc   = er;
    rst_now  = RST;
    if (RST) begin
      starve = 0;
      exp_rv[cyc+1] = 1'b0;
      exp_ew[cyc+1] = 1'b0;
      exp_rv[cyc+2] = 1'b0;
      exp_ew[cyc+2] = 1'b0;
    end else begin
      if (EX_EN && !er) starve = (starve < SL) ? starve + 1 : SL;
      else starve = 0;
      if (er && !EX_WE) begin
        exp_rv[cyc+2] = 1'b1;
        exp_rd[cyc+2] = mem[int'(EX_ADDR)];
      end
      if (cr && !CORE_WRITE) begin
        exp_ew[cyc+2]   = 1'b1;
        exp_dst[cyc+2]  = int'(CORE_DST);
        exp_word[cyc+2] = mem[int'(CORE_ADDR)];
      end
      if (er && EX_WE) mem[int'(EX_ADDR)] = merge(mem[int'(EX_ADDR)], EX_WDATA, em);
      if (cr && CORE_WRITE)
        mem[int'(CORE_ADDR)] = merge(mem[int'(CORE_ADDR)], CORE_WDATA, cm);
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (rst_now) begin
      last_rd   = '0;
      last_ew0a = '0;
      last_ew1a = '0;
      last_ew0d = '0;
      last_ew1d = '0;
    end
    if (exp_rv[cyc]) last_rd = exp_rd[cyc];
    if (exp_ew[cyc]) begin
      last_ew0a = GW'(exp_dst[cyc]);
      last_ew1a = GW'((exp_dst[cyc] + 1) % GC);
      last_ew0d = exp_word[cyc][DW-1:HW];
      last_ew1d = exp_word[cyc][HW-1:0];
    end
    check("ex_rvalid", {255'b0, EX_RVALID}, {255'b0, exp_rv[cyc]});
    check("ex_rdata",  EX_RDATA, last_rd);
    check("ew_en",     {255'b0, EW_EN}, {255'b0, exp_ew[cyc]});
    check("ew0_addr",  {250'b0, EW0_ADDR}, {250'b0, last_ew0a});
    check("ew1_addr",  {250'b0, EW1_ADDR}, {250'b0, last_ew1a});
    check("ew0_data",  {128'b0, EW0_DATA}, {128'b0, last_ew0d});
    check("ew1_data",  {128'b0, EW1_DATA}, {128'b0, last_ew1d});
  endtask

  task automatic idle();
    CORE_EN = 1'b0;
    EX_EN   = 1'b0;
  endtask

  task automatic core_req(input bit we, input int addr, input logic [DW-1:0] d,
                          input int dst);
    CORE_EN = 1'b1; CORE_WRITE = we; CORE_ADDR = AW'(addr);
    CORE_WDATA = d; CORE_DST = GW'(dst);
  endtask

  task automatic ex_req(input bit we, input int addr, input logic [DW-1:0] d);
    EX_EN = 1'b1; EX_WE = we; EX_ADDR = AW'(addr); EX_WDATA = d;
  endtask

  initial begin
    int denied;
    logic [DW-1:0] a5;

    // Reset with live requests: nothing accepted, all outputs zero.
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_req(1'($urandom_range(1)), $urandom_range(63), rnd_word(), $urandom_range(63));
      ex_req(1'($urandom_range(1)), $urandom_range(63), rnd_word());
      tick();
    end
    RST = 1'b0;
    idle();
    tick();

    // Preload addresses 0..63 through the core port.
    for (int a = 0; a < 64; a++) begin
      core_req(1'b1, a, rnd_word(), 0);
      tick();
    end
    idle();
    tick();

    // Core read of addr 5 (bank 1) into GPRs 62/63.
    core_req(1'b0, 5, '0, 62);
    tick();
    idle();
    tick();
    check("dst62_ew0_addr", {250'b0, EW0_ADDR}, 256'd62);
    check("dst62_ew1_addr", {250'b0, EW1_ADDR}, 256'd63);

    // Different banks in the same cycle: both accepted.
    core_req(1'b0, 4, '0, 10);
    ex_req(1'b0, 5, '0);
    tick();
    idle();
    tick();
    tick();

    // Both ports hold addr 8: external starves for STARVE_LIMIT cycles.
    core_req(1'b0, 8, '0, 3);
    ex_req(1'b0, 8, '0);
    denied = 0;
    for (int k = 0; k < SL + 4; k++) begin
      tick();
      if (ex_acc) break;
      denied++;
    end
    check("starve_denied_cycles", DW'(denied), DW'(SL));
    idle();
    tick();
    tick();

    // External write then core read of the same address next cycle.
    a5 = {32{8'hA5}};
    ex_req(1'b1, 3, a5);
    tick();
    idle();
    core_req(1'b0, 3, '0, 20);
    tick();
    idle();
    tick();
    check("wr_then_rd", {EW0_DATA, EW1_DATA}, a5);
    tick();

`ifdef MTSP_LMB_WRITE_MASK_EN
    // DWORD 0 only of all-ones over a zero word.
    CORE_WMASK = '1;
    core_req(1'b1, 20, '0, 0);
    tick();
    idle();
    EX_WMASK = MW'(1);
    ex_req(1'b1, 20, '1);
    tick();
    idle();
    EX_WMASK = '1;
    core_req(1'b0, 20, '0, 0);
    tick();
    idle();
    tick();
    check("mask_dword0", {EW0_DATA, EW1_DATA}, {{(DW-32){1'b0}}, 32'hFFFF_FFFF});
    tick();
`endif

    // Randomized traffic; refused requests are held stable.
    for (int i = 0; i < 600; i++) begin
`ifdef MTSP_LMB_WRITE_MASK_EN
      if (!(CORE_EN && !core_acc)) CORE_WMASK = MW'($urandom());
      if (!(EX_EN && !ex_acc)) EX_WMASK = MW'($urandom());
`endif
      if (!(CORE_EN && !core_acc)) begin
        CORE_EN    = ($urandom_range(3) != 0);
        CORE_WRITE = ($urandom_range(3) == 0);
        CORE_ADDR  = AW'($urandom_range(63));
        CORE_WDATA = rnd_word();
        CORE_DST   = GW'($urandom_range(63));
      end
      if (!(EX_EN && !ex_acc)) begin
        EX_EN    = ($urandom_range(3) != 0);
        EX_WE    = ($urandom_range(3) == 0);
        EX_ADDR  = AW'($urandom_range(63));
        EX_WDATA = rnd_word();
      end
      tick();
    end
    idle();
    tick();
    tick();

    // Reset one cycle after an accepted external read: no return.
    ex_req(1'b0, 9, '0);
    tick();
    RST = 1'b1;
    ex_req(1'b0, 10, '0);
    core_req(1'b0, 11, '0, 5);
    tick();
    tick();
    RST = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mtsp_lmb_banked.md
MTSP_LMB_BANKED -- requirements
Module: MTSP_LMB_BANKED

Interface
REQ-001 Parameter CORE_ID, default 0, core index for the simulation-side LMB mirror.
REQ-002 Parameter BANK_COUNT, default 4, number of interleaved SRAM banks; power of two, 1..8.
REQ-003 Parameter BANK_DEPTH, default 256, words per bank; power of two.
REQ-004 Parameter DATA_WIDTH, default 256, word width; multiple of 64.
REQ-005 Parameter GPR_COUNT, default 64, write-back register file size; power of two.
REQ-006 Parameter STARVE_LIMIT, default 8, maximum consecutive denied external cycles; 1..255.
REQ-007 Clocking: one clock CLK; reset RST is synchronous and active-high.
REQ-008 CLK  in  1  main clock.
REQ-009 RST  in  1  synchronous active-high reset.
REQ-010 CORE_EN / CORE_WRITE  in  1 / 1  core request and write select.
REQ-011 CORE_ADDR  in  AW=log2(BANK_COUNT*BANK_DEPTH)  core word address.
REQ-012 CORE_WDATA  in  DATA_WIDTH  core write data.
REQ-013 CORE_DST  in  log2(GPR_COUNT)  write-back base GPR index.
REQ-014 CORE_READY  out  1  core request accepted this cycle.
REQ-015 EX_EN / EX_WE  in  1 / 1  external request and write select.
REQ-016 EX_ADDR / EX_WDATA  in  AW / DATA_WIDTH  external address and write data.
REQ-017 EX_READY  out  1  external request accepted this cycle.
REQ-018 EX_RVALID / EX_RDATA  out  1 / DATA_WIDTH  external read return.
REQ-019 EW_EN  out  1  write-back valid, shared by both phases.
REQ-020 EW0_ADDR, EW1_ADDR  out  log2(GPR_COUNT) each  write-back GPR indices.
REQ-021 EW0_DATA, EW1_DATA  out  DATA_WIDTH/2 each  write-back data halves.

Function
REQ-022 Bank select SHALL be ADDR[log2(BANK_COUNT)-1:0]; row SHALL be the remaining upper bits.
REQ-023 Requests to different banks SHALL both be accepted in the same cycle.
REQ-024 Same-bank conflict: core SHALL win unless starve counter equals STARVE_LIMIT, in which case external wins and CORE_READY SHALL be 0.
REQ-025 Starve counter SHALL increment on each cycle with EX_EN=1 and EX_READY=0, saturate at STARVE_LIMIT, and clear to 0 on any cycle with EX_READY=1 or EX_EN=0.
REQ-026 A requester whose READY is 0 SHALL hold its request stable; the block SHALL NOT latch unaccepted requests.
REQ-027 External read SHALL return EX_RVALID=1 for exactly one cycle, 2 cycles after acceptance; EX_RDATA SHALL hold its last value otherwise.
REQ-028 Core read SHALL assert EW_EN 2 cycles after acceptance with EW0_ADDR=CORE_DST, EW1_ADDR=(CORE_DST+1) mod GPR_COUNT, EW0_DATA=upper half, EW1_DATA=lower half.
REQ-029 EW addresses and data SHALL hold their last values while EW_EN=0.
REQ-030 Writes SHALL produce no return; a read accepted in the cycle after a write to the same address SHALL return the new data.
REQ-031 Back-to-back reads SHALL be fully pipelined at one per cycle per port.

Reset
REQ-032 On RST: CORE_READY, EX_READY, EX_RVALID, EW_EN, starve counter SHALL be 0; EX_RDATA, EW0/EW1_ADDR, EW0/EW1_DATA SHALL be 0.
REQ-033 Requests presented while RST=1 SHALL be ignored; reads in flight at RST assertion SHALL be dropped without returns.
REQ-034 SRAM contents SHALL NOT be cleared by RST.

Configuration
REQ-035 Macro MTSP_LMB_WRITE_MASK_EN: when defined, inputs CORE_WMASK and EX_WMASK (DATA_WIDTH/32 bits each) SHALL gate writes per DWORD, 1=write.
REQ-036 Without MTSP_LMB_WRITE_MASK_EN the mask ports SHALL be absent and every write SHALL update the full word.

Structure
REQ-037 MTSP_LMB_pkg SHALL hold the request struct (en, we, addr, wdata, mask) and bank/row index width functions.
REQ-038 Banks SHALL instantiate the existing SRAM_Single; one sub-module, MTSP_LMB_BankArbiter, SHALL implement per-bank grant and the starve counter.

Verification
REQ-039 Core read addr 5 (bank 1, 4 banks) with DST=62 and stored word W -> after 2 cycles EW_EN=1, EW0_ADDR=62, EW1_ADDR=63, EW0_DATA=W[255:128], EW1_DATA=W[127:0].
REQ-040 Core addr 4 and external addr 5 in one cycle -> both READY=1; EX_RVALID after 2 cycles.
REQ-041 Core and external both hold addr 8 continuously, STARVE_LIMIT=8 -> EX_READY=0 for 8 cycles, then EX_READY=1 and CORE_READY=0 for one cycle.
REQ-042 External write 0xA5.. to addr 3, then core read addr 3 next cycle -> EW data equals 0xA5...
REQ-043 RST asserted one cycle after an accepted external read -> EX_RVALID never asserts; all outputs 0.
REQ-044 With MTSP_LMB_WRITE_MASK_EN, mask 0x01 write of all-ones over zero word -> readback equals 0x...FFFFFFFF in DWORD 0 only.
